regfile_bypass: RTL and testbench

- Parametrised successor to the CPU's two-read-port register file with EX/MEM/WB forwarding.
- Provides NUM_RD read ports and NUM_FWD prioritised forwarding sources, each with a data-ready flag.
- Adds a per-register pending scoreboard for long-latency producers (divider, multi-cycle loads).
- Raises a per-port stall when an operand cannot be supplied this cycle. It sits in ID and feeds the hazard/stall controller.

---
 rtl/regfile_bypass_pkg.sv | 12 +
 rtl/rf_read_port.sv | 59 +++++
 rtl/regfile_bypass.sv | 90 +++++++++
 tb/tb_regfile_bypass.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_bypass_pkg.sv
// Shared defaults and helpers for the bypassing register file.
package regfile_bypass_pkg;

   localparam int unsigned RF_DATA_W = 32;
   localparam int unsigned RF_ADDR_W = 5;

   // Width of one packed forwarding source: {we, rdy, waddr, wdata}.
   function automatic int unsigned rf_fwd_wd(input int unsigned aw, input int unsigned dw);
      return 2 + aw + dw;
   endfunction

endpackage

// File: rtl/rf_read_port.sv
// One read port: prioritised forward mux, write-through, scoreboard stall.
module rf_read_port
   import regfile_bypass_pkg::*;
#(
   parameter int unsigned DATA_W  = RF_DATA_W,
   parameter int unsigned ADDR_W  = RF_ADDR_W,
   parameter int unsigned NUM_FWD = 3
) (
   input  logic [ADDR_W-1:0]         addr,
   input  logic [DATA_W-1:0]         reg_data,
   input  logic                      pend,
   input  logic [NUM_FWD-1:0]        fwd_we,
   input  logic [NUM_FWD-1:0]        fwd_rdy,
   input  logic [NUM_FWD*ADDR_W-1:0] fwd_waddr,
   input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
   input  logic                      we,
   input  logic [ADDR_W-1:0]         waddr,
   input  logic [DATA_W-1:0]         wdata,
   output logic [DATA_W-1:0]         data_c,
   output logic                      stall_c
);

   logic              hit;
   logic              hit_rdy;
   logic [DATA_W-1:0] hit_data;

   // Scan oldest to youngest so the lowest matching index wins.
   always_comb begin
      hit      = 1'b0;
      hit_rdy  = 1'b0;
      hit_data = '0;
      for (int j = int'(NUM_FWD) - 1; j >= 0; j--) begin
         if (fwd_we[j] && (fwd_waddr[j*ADDR_W +: ADDR_W] == addr)) begin
            hit      = 1'b1;
            hit_rdy  = fwd_rdy[j];
            hit_data = fwd_wdata[j*DATA_W +: DATA_W];
         end
      end
   end

   // An unready youngest match stalls rather than falling through to older data.
   always_comb begin
      data_c  = '0;
      stall_c = 1'b0;
      if (addr == '0) begin
         data_c = '0;
      end else if (hit) begin
         if (hit_rdy) data_c  = hit_data;
         else         stall_c = 1'b1;
      end else if (we && (waddr == addr)) begin
         data_c = wdata;
      end else if (pend) begin
         stall_c = 1'b1;
      end else begin
         data_c = reg_data;
      end
   end

endmodule

// File: rtl/regfile_bypass.sv
// Register file with multi-source forwarding and a pending scoreboard for
// long-latency producers; feeds the ID-stage hazard/stall controller.
module regfile_bypass
   import regfile_bypass_pkg::*;
#(
   parameter int unsigned DATA_W  = RF_DATA_W,
   parameter int unsigned ADDR_W  = RF_ADDR_W,
   parameter int unsigned NUM_RD  = 2,
   parameter int unsigned NUM_FWD = 3,
   parameter bit          SB_EN   = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_RD*ADDR_W-1:0]  raddr,
   output logic [NUM_RD*DATA_W-1:0]  rdata,
   output logic [NUM_RD-1:0]         rd_stall,
   input  logic [NUM_FWD-1:0]        fwd_we,
   input  logic [NUM_FWD*ADDR_W-1:0] fwd_waddr,
   input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
   input  logic [NUM_FWD-1:0]        fwd_rdy,
   input  logic                      we,
   input  logic [ADDR_W-1:0]         waddr,
   input  logic [DATA_W-1:0]         wdata,
   input  logic                      pend_set,
   input  logic [ADDR_W-1:0]         pend_addr,
   input  logic                      flush,
   output logic [(2**ADDR_W)-1:0]    pend_vec
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] rf_q [DEPTH];
   logic [DEPTH-1:0]  pend_q;

   // Architectural storage; r0 is never written and stays zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < int'(DEPTH); k++) rf_q[k] <= '0;
      end else if (we && (waddr != '0)) begin
         rf_q[waddr] <= wdata;
      end
   end

   generate
      if (SB_EN) begin : g_sb
         // Set is applied after clear so a same-cycle re-issue stays pending.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               pend_q <= '0;
            end else if (flush) begin
               pend_q <= '0;
            end else begin
               if (we && (waddr != '0))          pend_q[waddr]     <= 1'b0;
               if (pend_set && (pend_addr != '0)) pend_q[pend_addr] <= 1'b1;
            end
         end
      end else begin : g_no_sb
         logic unused_sb;
         assign unused_sb = ^{pend_set, pend_addr, flush};
         assign pend_q    = '0;
      end
   endgenerate

   assign pend_vec = pend_q;

   for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      assign addr = raddr[i*ADDR_W +: ADDR_W];

      rf_read_port #(
         .DATA_W  (DATA_W),
         .ADDR_W  (ADDR_W),
         .NUM_FWD (NUM_FWD)
      ) u_port (
         .addr      (addr),
         .reg_data  (rf_q[addr]),
         .pend      (pend_q[addr]),
         .fwd_we    (fwd_we),
         .fwd_rdy   (fwd_rdy),
         .fwd_waddr (fwd_waddr),
         .fwd_wdata (fwd_wdata),
         .we        (we),
         .waddr     (waddr),
         .wdata     (wdata),
         .data_c    (rdata[i*DATA_W +: DATA_W]),
         .stall_c   (rd_stall[i])
      );
   end

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed self-checking bench for regfile_bypass (default parameters).
module tb_regfile_bypass;

   logic        clk;
   logic        rst;
   logic [9:0]  raddr;
   logic [63:0] rdata;
   logic [1:0]  rd_stall;
   logic [2:0]  fwd_we;
   logic [14:0] fwd_waddr;
   logic [95:0] fwd_wdata;
   logic [2:0]  fwd_rdy;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        pend_set;
   logic [4:0]  pend_addr;
   logic        flush;
   logic [31:0] pend_vec;

   int checks = 0;
   int errors = 0;

   regfile_bypass dut (
      .clk       (clk),
      .rst       (rst),
      .raddr     (raddr),
      .rdata     (rdata),
      .rd_stall  (rd_stall),
      .fwd_we    (fwd_we),
      .fwd_waddr (fwd_waddr),
      .fwd_wdata (fwd_wdata),
      .fwd_rdy   (fwd_rdy),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .pend_set  (pend_set),
      .pend_addr (pend_addr),
      .flush     (flush),
      .pend_vec  (pend_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fwd(input int j, input logic en, input logic rdy,
                          input logic [4:0] a, input logic [31:0] d);
      fwd_we[j]              = en;
      fwd_rdy[j]             = rdy;
      fwd_waddr[j*5 +: 5]    = a;
      fwd_wdata[j*32 +: 32]  = d;
   endtask

   initial begin
      rst = 1'b1; raddr = '0; fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0;
      fwd_rdy = '0; we = 1'b0; waddr = '0; wdata = '0; pend_set = 1'b0;
      pend_addr = '0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      raddr = {5'd31, 5'd5};
      #1;
      chk("reset_r5",    64'(rdata[31:0]),  64'h0);
      chk("reset_r31",   64'(rdata[63:32]), 64'h0);
      chk("reset_stall", 64'(rd_stall),     64'h0);
      chk("reset_pend",  64'(pend_vec),     64'h0);

      // Forwarding priority
      we = 1'b1; waddr = 5'd3; wdata = 32'h1111_1111;
      tick();
      we = 1'b0;
      set_fwd(2, 1'b1, 1'b1, 5'd3, 32'h2222_2222);
      set_fwd(1, 1'b1, 1'b1, 5'd3, 32'h3333_3333);
      set_fwd(0, 1'b1, 1'b1, 5'd3, 32'h4444_4444);
      raddr = {5'd3, 5'd3};
      #1;
      chk("fwd0_wins",  64'(rdata[31:0]),  64'h4444_4444);
      chk("fwd0_port1", 64'(rdata[63:32]), 64'h4444_4444);
      fwd_we[0] = 1'b0;
      #1 chk("fwd1_wins", 64'(rdata[31:0]), 64'h3333_3333);
      fwd_we[1] = 1'b0;
      #1 chk("fwd2_wins", 64'(rdata[31:0]), 64'h2222_2222);
      fwd_we[2] = 1'b0;
      #1 chk("reg_r3",    64'(rdata[31:0]), 64'h1111_1111);

      // Unready youngest source must not fall through
      set_fwd(0, 1'b1, 1'b0, 5'd7, 32'h0000_7777);
      set_fwd(1, 1'b1, 1'b1, 5'd7, 32'h0000_DEAD);
      raddr = {5'd3, 5'd7};
      #1;
      chk("unrdy_stall", 64'(rd_stall), 64'h1);
      chk("unrdy_data",  64'(rdata[31:0]), 64'h0);
      fwd_rdy[0] = 1'b1;
      #1;
      chk("rdy_data",  64'(rdata[31:0]), 64'h0000_7777);
      chk("rdy_stall", 64'(rd_stall),    64'h0);
      fwd_we = '0; fwd_rdy = '0;
      tick();

      // Scoreboard set / clear / write-through
      pend_set = 1'b1; pend_addr = 5'd9;
      tick();
      pend_set = 1'b0;
      raddr = {5'd3, 5'd9};
      #1;
      chk("pend9_set",   64'(pend_vec[9]), 64'h1);
      chk("pend9_stall", 64'(rd_stall),    64'h1);
      we = 1'b1; waddr = 5'd9; wdata = 32'hABCD_0000;
      #1;
      chk("wt_data",  64'(rdata[31:0]), 64'hABCD_0000);
      chk("wt_stall", 64'(rd_stall),    64'h0);
      tick();
      we = 1'b0;
      #1;
      chk("pend9_clr", 64'(pend_vec), 64'h0);
      chk("r9_stored", 64'(rdata[31:0]), 64'hABCD_0000);

      // Same-cycle set and commit: younger issue wins
      pend_set = 1'b1; pend_addr = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 32'h5;
      tick();
      pend_set = 1'b0; we = 1'b0;
      chk("set_commit", 64'(pend_vec[9]), 64'h1);

      // Re-issue to a pending register; a single commit releases it
      pend_set = 1'b1;
      tick();
      pend_set = 1'b0; we = 1'b1; waddr = 5'd9; wdata = 32'h6;
      tick();
      we = 1'b0;
      chk("single_release", 64'(pend_vec), 64'h0);

      // Flush beats a same-cycle set
      pend_set = 1'b1; pend_addr = 5'd9;
      tick();
      pend_addr = 5'd4; flush = 1'b1;
      tick();
      pend_set = 1'b0; flush = 1'b0;
      chk("flush", 64'(pend_vec), 64'h0);

      // r0 is hardwired
      we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
      set_fwd(0, 1'b1, 1'b1, 5'd0, 32'h5);
      pend_set = 1'b1; pend_addr = 5'd0;
      raddr = {5'd3, 5'd0};
      #1;
      chk("r0_data",  64'(rdata[31:0]), 64'h0);
      chk("r0_stall", 64'(rd_stall),    64'h0);
      tick();
      we = 1'b0; pend_set = 1'b0; fwd_we = '0; fwd_rdy = '0;
      #1;
      chk("r0_pend",  64'(pend_vec[0]), 64'h0);
      chk("r0_after", 64'(rdata[31:0]), 64'h0);

      // Asynchronous reset mid-stall
      we = 1'b1; waddr = 5'd12; wdata = 32'h77;
      tick();
      we = 1'b0;
      raddr = {5'd12, 5'd12};
      #1 chk("r12_stored", 64'(rdata[31:0]), 64'h77);
      pend_set = 1'b1; pend_addr = 5'd12;
      tick();
      pend_set = 1'b0;
      #1;
      chk("r12_pend",  64'(pend_vec[12]), 64'h1);
      chk("r12_stall", 64'(rd_stall),     64'h3);
      #1 rst = 1'b1;
      #1;
      chk("arst_pend",  64'(pend_vec),      64'h0);
      chk("arst_stall", 64'(rd_stall),      64'h0);
      chk("arst_data",  64'(rdata[31:0]),   64'h0);
      chk("arst_data1", 64'(rdata[63:32]),  64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
